// File: rtl/edge_irq_ctrl_if.sv
// CPU-side interrupt handshake for edge_irq_ctrl.
// The controller drives valid/id; the CPU answers with ack.
interface edge_irq_ctrl_if #(
  parameter int IDW = 3
);
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           irq_ack;

  modport master (
    output irq_valid,
    output irq_id,
    input  irq_ack
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    output irq_ack
  );
endinterface

// File: rtl/edge_irq_ctrl.sv
// Edge-triggered interrupt controller: sync, edge capture, sticky
// pending/overflow bits and round-robin presentation to one CPU port.
module edge_irq_ctrl #(
  parameter int NREQ = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] en,
  input  logic            clr_we,
  input  logic [NREQ-1:0] clr_data,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] ovf,
  edge_irq_ctrl_if.master irq
);

  typedef enum logic {
    S_IDLE,
    S_PRESENT
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [NREQ-1:0] r_sync1;
  logic [NREQ-1:0] r_sync2;
  logic [NREQ-1:0] r_old;
  logic [NREQ-1:0] r_pending;
  logic [NREQ-1:0] r_ovf;
  logic [IDW-1:0]  r_irq_id;
  logic [IDW-1:0]  r_last;

  logic [NREQ-1:0] w_edge;
  logic [NREQ-1:0] w_swclr;
  logic [NREQ-1:0] w_ackclr;
  logic [NREQ-1:0] w_clr;
  logic [NREQ-1:0] w_req;
  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic [IDW-1:0]  w_id_n;
  logic [IDW-1:0]  w_last_n;
  logic            w_ack;

  assign w_edge   = r_sync2 & ~r_old;
  assign w_swclr  = clr_we ? clr_data : '0;
  assign w_ackclr = w_ack ? (NREQ'(1) << r_irq_id) : '0;
  assign w_clr    = w_swclr | w_ackclr;
  assign w_req    = r_pending & en;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_old     <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
    end else begin
      r_sync1   <= req_i;
      r_sync2   <= r_sync1;
      r_old     <= r_sync2;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_ovf     <= (r_ovf & ~w_swclr)
                 | (w_edge & r_pending & ~w_clr);
    end
  end

  // Search upward from the line after the last grant, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && w_req[idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_id_n    = r_irq_id;
    w_last_n  = r_last;
    w_ack     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n = S_PRESENT;
          w_id_n    = w_pick;
        end
      end
      S_PRESENT: begin
        if (irq.irq_ack) begin
          w_ack     = 1'b1;
          w_last_n  = r_irq_id;
          w_state_n = S_IDLE;
        end else if (!en[r_irq_id] || w_swclr[r_irq_id]) begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= S_IDLE;
      r_irq_id <= '0;
      r_last   <= IDW'(NREQ - 1);
    end else begin
      r_state  <= w_state_n;
      r_irq_id <= w_id_n;
      r_last   <= w_last_n;
    end
  end

  assign pending       = r_pending;
  assign ovf           = r_ovf;
  assign irq.irq_valid = (r_state == S_PRESENT);
  assign irq.irq_id    = r_irq_id;

endmodule
